// File: rtl/i2c_register_sequencer.sv
// i2c_register_sequencer: expands one register-access request into the
// START / WR / RESTART / RD / STOP command stream of a byte-level I2C master.
//
// Handshakes:
//   Request side: a request transfers on a rising edge where i_req_valid and
//   o_req_ready are both 1. o_req_ready is 1 only while idle; requests seen
//   while busy are dropped, not queued.
//   Controller side: a command is offered only when i_ready=1 and is marked by
//   a one-cycle o_wr_i2c strobe. i_ready falling means the controller took it.
//   i_ready rising again means it finished; i_ack and i_dout are valid in that
//   cycle.
module i2c_register_sequencer #(
    parameter int MAX_LEN = 4,
    parameter int LEN_W   = 3
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_req_valid,
    output logic             o_req_ready,
    input  logic             i_req_rw,
    input  logic [6:0]       i_dev_addr,
    input  logic [7:0]       i_reg_addr,
    input  logic [LEN_W-1:0] i_len,
    input  logic [7:0]       i_wdata,
    output logic             o_wdata_req,
    output logic [7:0]       o_rdata,
    output logic             o_rdata_valid,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_nack_err,
    output logic [2:0]       o_cmd,
    output logic             o_wr_i2c,
    output logic [7:0]       o_din,
    input  logic             i_ready,
    input  logic             i_ack,
    input  logic [7:0]       i_dout,
    output logic [3:0]       o_dbg_phase,
    output logic [1:0]       o_dbg_sub
);

    localparam logic [2:0] CMD_START   = 3'b001;
    localparam logic [2:0] CMD_WR      = 3'b010;
    localparam logic [2:0] CMD_RD      = 3'b011;
    localparam logic [2:0] CMD_STOP    = 3'b100;
    localparam logic [2:0] CMD_RESTART = 3'b101;

    typedef enum logic [3:0] {
        PH_IDLE, PH_START, PH_DEVW, PH_REG, PH_RESTART,
        PH_DEVR, PH_DATA, PH_STOP, PH_DONE
    } phase_t;

    // SUB_FETCH only precedes write-data ISSUE; it is the o_wdata_req cycle.
    typedef enum logic [1:0] {
        SUB_ISSUE, SUB_WAIT_LO, SUB_WAIT_HI, SUB_FETCH
    } sub_t;

    phase_t           phase;
    sub_t             sub;
    logic             rw_q;
    logic [6:0]       dev_q;
    logic [7:0]       reg_q;
    logic [7:0]       wdata_q;
    logic [LEN_W-1:0] last_q;     // index of the final data byte
    logic [LEN_W-1:0] cnt_q;      // current data byte index
    logic [LEN_W-1:0] req_last;
    logic [2:0]       issue_cmd;
    logic [7:0]       issue_din;
    logic             issue_is_wr;

    assign o_dbg_phase = phase;
    assign o_dbg_sub   = sub;

    // Normalise the requested length to a last-byte index (0 -> 1 byte, clamp to MAX_LEN).
    always_comb begin
        if (i_len == '0)
            req_last = '0;
        else if (int'(i_len) > MAX_LEN)
            req_last = LEN_W'(MAX_LEN - 1);
        else
            req_last = i_len - LEN_W'(1);
    end

    // Command and byte the current phase hands to the controller.
    always_comb begin
        issue_cmd = CMD_STOP;
        issue_din = 8'h00;
        case (phase)
            PH_START:   issue_cmd = CMD_START;
            PH_DEVW:    begin issue_cmd = CMD_WR; issue_din = {dev_q, 1'b0}; end
            PH_REG:     begin issue_cmd = CMD_WR; issue_din = reg_q;         end
            PH_RESTART: issue_cmd = CMD_RESTART;
            PH_DEVR:    begin issue_cmd = CMD_WR; issue_din = {dev_q, 1'b1}; end
            PH_DATA: begin
                if (rw_q) begin
                    issue_cmd = CMD_RD;
                    // bit0 = 1 makes the controller NACK the final read byte
                    issue_din = (cnt_q == last_q) ? 8'h01 : 8'h00;
                end else begin
                    issue_cmd = CMD_WR;
                    issue_din = wdata_q;
                end
            end
            default:    issue_cmd = CMD_STOP;
        endcase
    end

    assign issue_is_wr = (issue_cmd == CMD_WR);

    // Sequencer FSM: phase walks the transaction, sub walks each controller handshake.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            phase         <= PH_IDLE;
            sub           <= SUB_ISSUE;
            rw_q          <= 1'b0;
            dev_q         <= '0;
            reg_q         <= '0;
            wdata_q       <= '0;
            last_q        <= '0;
            cnt_q         <= '0;
            o_req_ready   <= 1'b1;
            o_wdata_req   <= 1'b0;
            o_rdata       <= '0;
            o_rdata_valid <= 1'b0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_nack_err    <= 1'b0;
            o_cmd         <= '0;
            o_wr_i2c      <= 1'b0;
            o_din         <= '0;
        end else begin
            o_wr_i2c      <= 1'b0;
            o_wdata_req   <= 1'b0;
            o_rdata_valid <= 1'b0;
            o_done        <= 1'b0;
            case (phase)
                PH_IDLE: begin
                    if (i_req_valid) begin
                        rw_q        <= i_req_rw;
                        dev_q       <= i_dev_addr;
                        reg_q       <= i_reg_addr;
                        last_q      <= req_last;
                        cnt_q       <= '0;
                        o_req_ready <= 1'b0;
                        o_busy      <= 1'b1;
                        o_nack_err  <= 1'b0;
                        phase       <= PH_START;
                        sub         <= SUB_ISSUE;
                    end
                end
                PH_DONE: begin
                    phase       <= PH_IDLE;
                    o_req_ready <= 1'b1;
                end
                default: begin
                    case (sub)
                        SUB_FETCH: begin
                            wdata_q <= i_wdata;
                            sub     <= SUB_ISSUE;
                        end
                        SUB_ISSUE: begin
                            if (i_ready) begin
                                o_cmd    <= issue_cmd;
                                o_din    <= issue_din;
                                o_wr_i2c <= 1'b1;
                                sub      <= SUB_WAIT_LO;
                            end
                        end
                        SUB_WAIT_LO: begin
                            if (!i_ready)
                                sub <= SUB_WAIT_HI;
                        end
                        SUB_WAIT_HI: begin
                            if (i_ready) begin
                                sub <= SUB_ISSUE;
                                if (issue_is_wr && i_ack) begin
                                    // Slave refused a byte: abandon the rest and release the bus.
                                    o_nack_err <= 1'b1;
                                    phase      <= PH_STOP;
                                end else begin
                                    case (phase)
                                        PH_START:   phase <= PH_DEVW;
                                        PH_DEVW:    phase <= PH_REG;
                                        PH_REG: begin
                                            if (rw_q) begin
                                                phase <= PH_RESTART;
                                            end else begin
                                                phase       <= PH_DATA;
                                                sub         <= SUB_FETCH;
                                                o_wdata_req <= 1'b1;
                                            end
                                        end
                                        PH_RESTART: phase <= PH_DEVR;
                                        PH_DEVR:    phase <= PH_DATA;
                                        PH_DATA: begin
                                            if (rw_q) begin
                                                o_rdata       <= i_dout;
                                                o_rdata_valid <= 1'b1;
                                            end
                                            if (cnt_q == last_q) begin
                                                phase <= PH_STOP;
                                            end else begin
                                                cnt_q <= cnt_q + LEN_W'(1);
                                                if (!rw_q) begin
                                                    sub         <= SUB_FETCH;
                                                    o_wdata_req <= 1'b1;
                                                end
                                            end
                                        end
                                        PH_STOP: begin
                                            phase  <= PH_DONE;
                                            o_done <= 1'b1;
                                            o_busy <= 1'b0;
                                        end
                                        default:    phase <= PH_IDLE;
                                    endcase
                                end
                            end
                        end
                        default: sub <= SUB_ISSUE;
                    endcase
                end
            endcase
        end
    end

endmodule
